// File: rtl/l2_noc_pkg.sv
// Shared NoC definitions: header field positions, FSM state encoding,
// message-type constants and the captured-header bundle.
package l2_noc_pkg;

    localparam int FLIT_W     = 64;
    localparam int HDR_FLITS  = 3;

    localparam int CHIPID_MSB = 63;
    localparam int CHIPID_LSB = 50;
    localparam int X_MSB      = 49;
    localparam int X_LSB      = 42;
    localparam int Y_MSB      = 41;
    localparam int Y_LSB      = 34;
    localparam int FBITS_MSB  = 33;
    localparam int FBITS_LSB  = 30;
    localparam int LEN_MSB    = 29;
    localparam int LEN_LSB    = 22;
    localparam int TYPE_MSB   = 21;
    localparam int TYPE_LSB   = 14;
    localparam int MSHRID_MSB = 13;
    localparam int MSHRID_LSB = 6;

    localparam logic [7:0] MSG_TYPE_STORE_REQ        = 8'd2;
    localparam logic [7:0] MSG_TYPE_LOAD_NOSHARE_REQ = 8'd13;
    localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ      = 8'd14;
    localparam logic [7:0] MSG_TYPE_NC_STORE_REQ     = 8'd15;
    localparam logic [7:0] MSG_TYPE_LOAD_MEM_ACK     = 8'd24;
    localparam logic [7:0] MSG_TYPE_STORE_MEM_ACK    = 8'd25;
    localparam logic [7:0] MSG_TYPE_NODATA_ACK       = 8'd28;
    localparam logic [7:0] MSG_TYPE_DATA_ACK         = 8'd29;
    localparam logic [7:0] MSG_TYPE_LOAD_REQ         = 8'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_DATA
    } state_t;

    // addr is already left-aligned into flit position
    typedef struct packed {
        logic [13:0] dst_chipid;
        logic [7:0]  dst_x;
        logic [7:0]  dst_y;
        logic [13:0] src_chipid;
        logic [7:0]  src_x;
        logic [7:0]  src_y;
        logic [7:0]  mtype;
        logic [7:0]  mshrid;
        logic [63:0] addr;
        logic [1:0]  dlen;
    } hdr_t;

endpackage

// File: rtl/l2_noc_msg_serializer_if.sv
// Message-in / flit-out bundle of the L2 NoC serializer.
// slave = serializer side, master = stimulus/consumer side.
interface l2_noc_msg_serializer_if #(
    parameter int ADDR_W = 40
);
    logic              msg_valid;
    logic              msg_ready;
    logic [7:0]        msg_type;
    logic [7:0]        msg_mshrid;
    logic [ADDR_W-1:0] msg_addr;
    logic [13:0]       msg_dst_chipid;
    logic [7:0]        msg_dst_x;
    logic [7:0]        msg_dst_y;
    logic [13:0]       msg_src_chipid;
    logic [7:0]        msg_src_x;
    logic [7:0]        msg_src_y;
    logic [1:0]        msg_dlen;
    logic [127:0]      msg_data;
    logic [63:0]       noc_data_out;
    logic              noc_valid_out;
    logic              noc_ready_in;

    modport slave (
        input  msg_valid, msg_type, msg_mshrid, msg_addr,
        input  msg_dst_chipid, msg_dst_x, msg_dst_y,
        input  msg_src_chipid, msg_src_x, msg_src_y,
        input  msg_dlen, msg_data, noc_ready_in,
        output msg_ready, noc_data_out, noc_valid_out
    );

    modport master (
        output msg_valid, msg_type, msg_mshrid, msg_addr,
        output msg_dst_chipid, msg_dst_x, msg_dst_y,
        output msg_src_chipid, msg_src_x, msg_src_y,
        output msg_dlen, msg_data, noc_ready_in,
        input  msg_ready, noc_data_out, noc_valid_out
    );

endinterface

// File: rtl/l2_noc_flit_fmt.sv
// Combinational NoC header flit assembly.
// Ports: f = captured header fields, idx = header flit 0..2, flit = result.
module l2_noc_flit_fmt
    import l2_noc_pkg::*;
(
    input  hdr_t        f,
    input  logic [1:0]  idx,
    output logic [63:0] flit
);

    always_comb begin
        flit = '0;
        unique case (idx)
            2'd0: begin
                flit[CHIPID_MSB:CHIPID_LSB] = f.dst_chipid;
                flit[X_MSB:X_LSB]           = f.dst_x;
                flit[Y_MSB:Y_LSB]           = f.dst_y;
                flit[FBITS_MSB:FBITS_LSB]   = '0;
                // payload length counts header flits 1..2 plus data
                flit[LEN_MSB:LEN_LSB]       = 8'd2 + {6'd0, f.dlen};
                flit[TYPE_MSB:TYPE_LSB]     = f.mtype;
                flit[MSHRID_MSB:MSHRID_LSB] = f.mshrid;
            end
            2'd1: begin
                flit = f.addr;
            end
            2'd2: begin
                flit[CHIPID_MSB:CHIPID_LSB] = f.src_chipid;
                flit[X_MSB:X_LSB]           = f.src_x;
                flit[Y_MSB:Y_LSB]           = f.src_y;
            end
            default: begin
                flit = '0;
            end
        endcase
    end

endmodule

// File: rtl/l2_noc_msg_serializer.sv
// Serializes one abstract L2 message into 3 header + 0..2 data NoC flits.
// Ports: clk, rst (sync, active-high), bus (slave), busy, len_err (sticky).
module l2_noc_msg_serializer
    import l2_noc_pkg::*;
#(
    parameter int ADDR_W   = 40,
    parameter int MAX_DATA = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    l2_noc_msg_serializer_if.slave  bus,
    output logic                    busy,
    output logic                    len_err
);

    localparam logic [1:0] MAX_D = 2'(MAX_DATA);

    state_t       state;
    hdr_t         cap;
    hdr_t         in_f;
    hdr_t         fmt_f;
    logic [127:0] cap_data;
    logic         dcnt;
    logic [1:0]   fmt_idx;
    logic [63:0]  fmt_flit;
    logic [63:0]  noc_data;
    logic         noc_valid;
    logic         msg_ready;
    logic         fire;
    logic         last_data;

    assign bus.msg_ready     = msg_ready;
    assign bus.noc_valid_out = noc_valid;
    assign bus.noc_data_out  = noc_data;

    assign fire      = noc_valid && bus.noc_ready_in;
    assign last_data = ({1'b0, dcnt} == (cap.dlen - 2'd1));

    always_comb begin
        in_f            = '0;
        in_f.dst_chipid = bus.msg_dst_chipid;
        in_f.dst_x      = bus.msg_dst_x;
        in_f.dst_y      = bus.msg_dst_y;
        in_f.src_chipid = bus.msg_src_chipid;
        in_f.src_x      = bus.msg_src_x;
        in_f.src_y      = bus.msg_src_y;
        in_f.mtype      = bus.msg_type;
        in_f.mshrid     = bus.msg_mshrid;
        in_f.addr       = 64'(bus.msg_addr) << (64 - ADDR_W);
        in_f.dlen       = (bus.msg_dlen > MAX_D) ? MAX_D
                                                 : bus.msg_dlen;
    end

    // The formatter looks one flit ahead so the output register
    // is loaded with the next flit when the current one fires.
    // In IDLE the capture registers are not yet written, so
    // header 0 is built from the live inputs.
    always_comb begin
        fmt_f   = cap;
        fmt_idx = 2'd0;
        unique case (state)
            S_IDLE: begin
                fmt_f   = in_f;
                fmt_idx = 2'd0;
            end
            S_HDR0:  fmt_idx = 2'd1;
            S_HDR1:  fmt_idx = 2'd2;
            default: fmt_idx = 2'd0;
        endcase
    end

    l2_noc_flit_fmt u_fmt (
        .f    (fmt_f),
        .idx  (fmt_idx),
        .flit (fmt_flit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cap       <= '0;
            cap_data  <= '0;
            dcnt      <= 1'b0;
            noc_data  <= '0;
            noc_valid <= 1'b0;
            msg_ready <= 1'b1;
            busy      <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.msg_valid) begin
                        cap       <= in_f;
                        cap_data  <= bus.msg_data;
                        if (bus.msg_dlen > MAX_D) begin
                            len_err <= 1'b1;
                        end
                        state     <= S_HDR0;
                        noc_data  <= fmt_flit;
                        noc_valid <= 1'b1;
                        msg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_HDR0: begin
                    if (fire) begin
                        state    <= S_HDR1;
                        noc_data <= fmt_flit;
                    end
                end
                S_HDR1: begin
                    if (fire) begin
                        state    <= S_HDR2;
                        noc_data <= fmt_flit;
                    end
                end
                S_HDR2: begin
                    if (fire) begin
                        if (cap.dlen != 2'd0) begin
                            state    <= S_DATA;
                            dcnt     <= 1'b0;
                            noc_data <= cap_data[63:0];
                        end else begin
                            state     <= S_IDLE;
                            noc_valid <= 1'b0;
                            msg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        if (last_data) begin
                            state     <= S_IDLE;
                            noc_valid <= 1'b0;
                            msg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            dcnt     <= 1'b1;
                            noc_data <= cap_data[127:64];
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    noc_valid <= 1'b0;
                    msg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_noc_msg_serializer.sv
// Directed self-checking bench for l2_noc_msg_serializer.
// Flits are logged by a monitor and compared to hand-built expectations.
module tb_l2_noc_msg_serializer;

    typedef struct {
        logic [7:0]   mtype;
        logic [7:0]   mshrid;
        logic [39:0]  addr;
        logic [13:0]  dchip;
        logic [7:0]   dx;
        logic [7:0]   dy;
        logic [13:0]  schip;
        logic [7:0]   sx;
        logic [7:0]   sy;
        logic [1:0]   dlen;
        logic [127:0] data;
    } msg_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic len_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [63:0] flits[$];
    int          fcyc[$];

    l2_noc_msg_serializer_if #(.ADDR_W(40)) bus ();

    l2_noc_msg_serializer #(
        .ADDR_W   (40),
        .MAX_DATA (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!rst && bus.noc_valid_out && bus.noc_ready_in) begin
            flits.push_back(bus.noc_data_out);
            fcyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_flit(input msg_t m, input int i);
        logic [1:0] d;
        d = (m.dlen > 2'd2) ? 2'd2 : m.dlen;
        case (i)
            0: return {m.dchip, m.dx, m.dy, 4'h0, 8'd2 + {6'd0, d},
                       m.mtype, m.mshrid, 6'h0};
            1: return {m.addr, 24'h0};
            2: return {m.schip, m.sx, m.sy, 34'h0};
            3: return m.data[63:0];
            default: return m.data[127:64];
        endcase
    endfunction

    function automatic int nflits(input msg_t m);
        return 3 + ((m.dlen > 2'd2) ? 2 : int'(m.dlen));
    endfunction

    task automatic drive(input msg_t m);
        bus.msg_type       = m.mtype;
        bus.msg_mshrid     = m.mshrid;
        bus.msg_addr       = m.addr;
        bus.msg_dst_chipid = m.dchip;
        bus.msg_dst_x      = m.dx;
        bus.msg_dst_y      = m.dy;
        bus.msg_src_chipid = m.schip;
        bus.msg_src_x      = m.sx;
        bus.msg_src_y      = m.sy;
        bus.msg_dlen       = m.dlen;
        bus.msg_data       = m.data;
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input string tag, input msg_t m, input bit keep);
        int k;
        drive(m);
        bus.msg_valid = 1'b1;
        k = 0;
        while (!bus.msg_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_accept_timeout"}, 64'(k >= 100), 64'd0);
        @(negedge clk);
        if (!keep) bus.msg_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((busy || bus.noc_valid_out) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drain_timeout"}, 64'(k >= 200), 64'd0);
    endtask

    task automatic check_pkt(input string tag, input msg_t m,
                             input int base);
        logic [63:0] obs;
        for (int i = 0; i < nflits(m); i++) begin
            obs = (base + i < flits.size()) ? flits[base + i] : 'x;
            check($sformatf("%s_f%0d", tag, i), obs, exp_flit(m, i));
            if (i > 0) begin
                check($sformatf("%s_gap%0d", tag, i),
                      (base + i < fcyc.size())
                        ? 64'(fcyc[base + i] - fcyc[base + i - 1])
                        : 'x,
                      64'd1);
            end
        end
    endtask

    msg_t m1, m2, m3, m4, m5, m6, m7, ma, mb, mc;
    logic [63:0] held;
    logic [63:0] f0;

    initial begin
        rst              = 1'b1;
        bus.msg_valid    = 1'b0;
        bus.noc_ready_in = 1'b1;
        m1 = '{8'h0D, 8'h05, 40'h12_3456_7800, 14'h0001, 8'h02,
               8'h03, 14'h0004, 8'h05, 8'h06, 2'd0, 128'h0};
        drive(m1);
        repeat (3) @(negedge clk);

        check("rst_msg_ready", 64'(bus.msg_ready), 64'd1);
        check("rst_valid", 64'(bus.noc_valid_out), 64'd0);
        check("rst_data", bus.noc_data_out, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: load, no data
        flits.delete(); fcyc.delete();
        send("t1", m1, 1'b0);
        check("t1_valid", 64'(bus.noc_valid_out), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready_lo", 64'(bus.msg_ready), 64'd0);
        check("t1_hdr0", bus.noc_data_out, 64'h0004_080C_0083_4140);
        repeat (2) @(negedge clk);
        check("t1_ready_hdr2", 64'(bus.msg_ready), 64'd0);
        @(negedge clk);
        check("t1_ready_back", 64'(bus.msg_ready), 64'd1);
        check("t1_valid_off", 64'(bus.noc_valid_out), 64'd0);
        check("t1_count", 64'(flits.size()), 64'd3);
        check("t1_hdr1", (flits.size() > 1) ? flits[1] : 'x,
              64'h1234_5678_0000_0000);
        check("t1_hdr2", (flits.size() > 2) ? flits[2] : 'x,
              64'h0010_1418_0000_0000);
        check_pkt("t1", m1, 0);

        // 2: store with two data words
        m2 = '{8'h02, 8'h11, 40'hFF_0000_0040, 14'h3FFF, 8'hFF,
               8'h00, 14'h0123, 8'h0A, 8'hB0, 2'd2,
               {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555}};
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t2", m2, 1'b0);
        drain("t2");
        check("t2_count", 64'(flits.size()), 64'd5);
        f0 = (flits.size() > 0) ? flits[0] : 'x;
        check("t2_len", 64'(f0[29:22]), 64'd4);
        check("t2_d0", (flits.size() > 3) ? flits[3] : 'x,
              64'h5555_5555_5555_5555);
        check("t2_d1", (flits.size() > 4) ? flits[4] : 'x,
              64'hAAAA_AAAA_AAAA_AAAA);
        check_pkt("t2", m2, 0);

        // 3: backpressure during HDR1
        m3 = '{8'h0F, 8'h3C, 40'h00_DEAD_BEC0, 14'h0002, 8'h01,
               8'h01, 14'h0003, 8'h02, 8'h02, 2'd1,
               {64'h0, 64'h0123_4567_89AB_CDEF}};
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t3", m3, 1'b0);
        @(negedge clk);
        bus.noc_ready_in = 1'b0;
        held = bus.noc_data_out;
        check("t3_hdr1_now", held, exp_flit(m3, 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t3_hold%0d", i), bus.noc_data_out, held);
            check($sformatf("t3_vhold%0d", i),
                  64'(bus.noc_valid_out), 64'd1);
        end
        bus.noc_ready_in = 1'b1;
        drain("t3");
        check("t3_count", 64'(flits.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_f%0d", i),
                  (flits.size() > i) ? flits[i] : 'x, exp_flit(m3, i));
        end

        // 4: oversize dlen clamps and sets sticky len_err
        m4 = '{8'h1F, 8'h77, 40'h01_0203_0400, 14'h0010, 8'h20,
               8'h30, 14'h0040, 8'h50, 8'h60, 2'd3,
               {64'hCAFE_F00D_0000_0001, 64'hBEEF_0000_1111_2222}};
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t4", m4, 1'b0);
        check("t4_len_err", 64'(len_err), 64'd1);
        drain("t4");
        check("t4_count", 64'(flits.size()), 64'd5);
        f0 = (flits.size() > 0) ? flits[0] : 'x;
        check("t4_len", 64'(f0[29:22]), 64'd4);
        check_pkt("t4", m4, 0);
        m5 = m3;
        m5.mshrid = 8'h42;
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t4b", m5, 1'b0);
        drain("t4b");
        check("t4_len_err_sticky", 64'(len_err), 64'd1);
        check_pkt("t4b", m5, 0);

        // 5: reset during DATA
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t5", m2, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valid", 64'(bus.noc_valid_out), 64'd0);
        check("t5_ready", 64'(bus.msg_ready), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_len_err", 64'(len_err), 64'd0);
        rst = 1'b0;
        m6 = '{8'h0E, 8'h09, 40'hAB_CDEF_0120, 14'h1234, 8'h44,
               8'h55, 14'h2345, 8'h66, 8'h77, 2'd1,
               {64'h0, 64'hFEDC_BA98_7654_3210}};
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t5b", m6, 1'b0);
        drain("t5b");
        check("t5b_count", 64'(flits.size()), 64'd4);
        check_pkt("t5b", m6, 0);

        // 6: msg_valid held across three messages
        ma = m1;
        mb = m6;
        mb.mshrid = 8'hA1;
        mc = m2;
        mc.mshrid = 8'hC3;
        m7 = mc;
        flits.delete(); fcyc.delete();
        @(negedge clk);
        send("t6a", ma, 1'b1);
        send("t6b", mb, 1'b1);
        send("t6c", m7, 1'b0);
        drain("t6");
        check("t6_count", 64'(flits.size()), 64'd12);
        check_pkt("t6a", ma, 0);
        check_pkt("t6b", mb, 3);
        check_pkt("t6c", mc, 7);
        check("t6_bubble_ab",
              (fcyc.size() > 3) ? 64'(fcyc[3] - fcyc[2]) : 'x, 64'd2);
        check("t6_bubble_bc",
              (fcyc.size() > 7) ? 64'(fcyc[7] - fcyc[6]) : 'x, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
